// File: rtl/uart_pkg.sv
// uart_pkg: register map, CFG/STATUS layouts, FSM states and frame helpers for uart_v2
package uart_pkg;

   localparam logic [2:0] REG_TXDATA = 3'd0;
   localparam logic [2:0] REG_RXDATA = 3'd1;
   localparam logic [2:0] REG_DIV    = 3'd2;
   localparam logic [2:0] REG_CFG    = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;

   typedef struct packed {
      logic       irq_err_en;
      logic       irq_tx_en;
      logic       irq_rx_en;
      logic       two_stop;
      logic [1:0] parity;
      logic [1:0] bits;
   } cfg_t;

   typedef struct packed {
      logic [1:0] rsvd;
      logic       overrun;
      logic       frame_err;
      logic       parity_err;
      logic       tx_busy;
      logic       rx_empty;
      logic       tx_full;
   } status_t;

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

   function automatic logic has_parity(input cfg_t c);
      return c.parity == 2'b01 || c.parity == 2'b10;
   endfunction

   function automatic logic [7:0] data_mask(input logic [1:0] bits);
      return 8'hFF >> (2'd3 - bits);
   endfunction

   // even parity is the XOR of the data bits; odd parity (2'b10) inverts it
   function automatic logic par_bit(input logic [7:0] d, input cfg_t c);
      return ^(d & data_mask(c.bits)) ^ c.parity[1];
   endfunction

endpackage

// File: rtl/fifo.sv
// fifo: synchronous byte queue; push when full and pop when empty are ignored
module fifo #(
   parameter int XLEN  = 8,
   parameter int DEPTH = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] din,
   output logic [XLEN-1:0] dout,
   output logic            full,
   output logic            empty
);
   localparam int AW = $clog2(DEPTH);

   logic [XLEN-1:0] mem [DEPTH];
   logic [AW-1:0]   wp, rp;
   logic [AW:0]     cnt;
   logic            do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = cnt == (AW+1)'(DEPTH);
   assign empty   = cnt == '0;
   assign dout    = mem[rp];

   // pointer and occupancy update; simultaneous push and pop leaves cnt unchanged
   always_ff @(posedge clk) begin
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) begin
            mem[wp] <= din;
            wp      <= wp + 1'b1;
         end
         if (do_pop) rp <= rp + 1'b1;
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/uart_v2.sv
// uart_v2: register-mapped UART with shared baud tick, TX/RX frame FSMs and byte FIFOs
module uart_v2
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int RX_QUEUE_SIZE = 16,
   parameter int TX_QUEUE_SIZE = 16,
   parameter int DIV_RESET     = 53
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sel,
   input  logic                  we,
   input  logic [2:0]            regsel,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  irq,
   output logic                  tx,
   input  logic                  rx
);
   logic        wr, rd, tick;
   logic [15:0] div, tick_cnt;
   cfg_t        cfg, tx_cfg, rx_cfg;
   status_t     status;
   logic        parity_err, frame_err, overrun, set_perr, set_ferr, set_ovr;
   logic [2:0]  clr;
   logic        tx_full, tx_empty, tx_pop, tx_par, tx_bit_end, tx_last_data;
   logic [7:0]  tx_head, tx_shift;
   logic [3:0]  tx_tcnt, rx_tcnt;
   logic [2:0]  tx_bcnt, rx_bcnt;
   tx_state_t   tx_state, tx_next;
   logic        rx_full, rx_empty, rx_push, rx_mid, rx_last_data;
   logic        rx_s1, rx_s2, rx_s3;
   logic [7:0]  rx_head, rx_shift, rx_data;
   rx_state_t   rx_state, rx_next;
   logic        unused_bits;

   assign wr           = sel && we;
   assign rd           = sel && !we;
   assign tick         = tick_cnt == div;
   assign clr          = wr && regsel == REG_STATUS ? din[5:3] : 3'b000;
   assign status       = {2'b00, overrun, frame_err, parity_err, tx_state != TX_IDLE, rx_empty, tx_full};
   assign tx_bit_end   = tick && tx_tcnt == 4'hF;
   assign tx_last_data = tx_bcnt == {1'b0, tx_cfg.bits} + 3'd4;
   assign rx_mid       = tick && rx_tcnt == 4'd7;
   assign rx_last_data = rx_bcnt == {1'b0, rx_cfg.bits} + 3'd4;
   assign rx_data      = rx_shift >> (2'd3 - rx_cfg.bits);
   assign rx_push      = rx_state == RX_STOP && rx_mid;
   assign set_perr     = rx_state == RX_PARITY && rx_mid && rx_s2 != par_bit(rx_data, rx_cfg);
   assign set_ferr     = rx_push && !rx_s2;
   assign set_ovr      = rx_push && rx_full;
   assign unused_bits  = ^{din[DATA_WIDTH-1:16], tx_cfg, rx_cfg};

   fifo #(.XLEN(8), .DEPTH(TX_QUEUE_SIZE)) u_tx_fifo (
      .clk, .reset, .push(wr && regsel == REG_TXDATA), .pop(tx_pop),
      .din(din[7:0]), .dout(tx_head), .full(tx_full), .empty(tx_empty)
   );

   fifo #(.XLEN(8), .DEPTH(RX_QUEUE_SIZE)) u_rx_fifo (
      .clk, .reset, .push(rx_push), .pop(rd && regsel == REG_RXDATA),
      .din(rx_data), .dout(rx_head), .full(rx_full), .empty(rx_empty)
   );

   // combinational read mux; an empty RXDATA read returns zero
   always_comb
      dout = regsel == REG_RXDATA ? DATA_WIDTH'(rx_empty ? 8'h00 : rx_head) :
             regsel == REG_DIV    ? DATA_WIDTH'(div) :
             regsel == REG_CFG    ? DATA_WIDTH'(cfg) :
             regsel == REG_STATUS ? DATA_WIDTH'(status) : '0;

   // config registers, sticky error flags (set beats clear), tick counter and registered irq
   always_ff @(posedge clk) begin
      if (reset) begin
         div        <= 16'(DIV_RESET);
         cfg        <= cfg_t'(8'h03);
         tick_cnt   <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         irq        <= 1'b0;
      end else begin
         if (wr && regsel == REG_DIV) div <= din[15:0];
         if (wr && regsel == REG_CFG) cfg <= cfg_t'(din[7:0]);
         tick_cnt   <= (wr && regsel == REG_DIV) || tick ? 16'd0 : tick_cnt + 16'd1;
         parity_err <= (parity_err && !clr[0]) || set_perr;
         frame_err  <= (frame_err && !clr[1]) || set_ferr;
         overrun    <= (overrun && !clr[2]) || set_ovr;
         irq        <= (cfg.irq_rx_en && !rx_empty) ||
                       (cfg.irq_tx_en && tx_empty && tx_state == TX_IDLE) ||
                       (cfg.irq_err_en && (parity_err || frame_err || overrun));
      end
   end

   // TX next state; every entry into START pops the next byte
   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      if (tx_state == TX_IDLE) tx_next = tx_empty ? TX_IDLE : TX_START;
      else if (tx_bit_end)
         case (tx_state)
            TX_START:  tx_next = TX_DATA;
            TX_DATA:   tx_next = !tx_last_data ? TX_DATA : has_parity(tx_cfg) ? TX_PARITY : TX_STOP1;
            TX_PARITY: tx_next = TX_STOP1;
            TX_STOP1:  tx_next = tx_cfg.two_stop ? TX_STOP2 : tx_empty ? TX_IDLE : TX_START;
            default:   tx_next = tx_empty ? TX_IDLE : TX_START;
         endcase
      tx_pop = tx_next == TX_START && tx_state != TX_START;
   end

   // TX state, frame latch (data, cfg, parity) on pop, bit timing and registered line
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_tcnt  <= '0;
         tx_bcnt  <= '0;
         tx       <= 1'b1;
      end else begin
         tx_state <= tx_next;
         tx_tcnt  <= tx_state == TX_IDLE ? 4'd0 : tx_tcnt + 4'(tick);
         if (tx_pop) begin
            tx_cfg   <= cfg;
            tx_shift <= tx_head;
            tx_par   <= par_bit(tx_head, cfg);
            tx_bcnt  <= '0;
         end else if (tx_state == TX_DATA && tx_bit_end) begin
            tx_shift <= tx_shift >> 1;
            tx_bcnt  <= tx_bcnt + 3'd1;
         end
         tx <= tx_state == TX_START  ? 1'b0 :
               tx_state == TX_DATA   ? tx_shift[0] :
               tx_state == TX_PARITY ? tx_par : 1'b1;
      end
   end

   // RX next state; START samples mid-bit to reject glitches, STOP returns to IDLE mid-bit
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:   rx_next = rx_s3 && !rx_s2 ? RX_START : RX_IDLE;
         RX_START:  if (rx_mid) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:   if (rx_mid && rx_last_data) rx_next = has_parity(rx_cfg) ? RX_PARITY : RX_STOP;
         RX_PARITY: if (rx_mid) rx_next = RX_STOP;
         default:   if (rx_mid) rx_next = RX_IDLE;
      endcase
   end

   // RX synchronizer, state, cfg tracking while idle and LSB-first shift-in
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_s3    <= 1'b1;
         rx_state <= RX_IDLE;
         rx_tcnt  <= '0;
         rx_bcnt  <= '0;
      end else begin
         rx_s1    <= rx;
         rx_s2    <= rx_s1;
         rx_s3    <= rx_s2;
         rx_state <= rx_next;
         rx_tcnt  <= rx_state == RX_IDLE ? 4'd0 : rx_tcnt + 4'(tick);
         if (rx_state == RX_IDLE) begin
            rx_cfg  <= cfg;
            rx_bcnt <= '0;
         end else if (rx_state == RX_DATA && rx_mid) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bcnt  <= rx_bcnt + 3'd1;
         end
      end
   end
endmodule

// File: tb/tb_uart_v2.sv
// tb_uart_v2: directed scenarios for uart_v2 with hand-computed expected values
module tb_uart_v2;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sel = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  regsel = 3'd0;
   logic [31:0] din = '0;
   logic [31:0] dout;
   logic        irq, tx, rx;
   logic        rx_drv = 1'b1;
   logic        loop_en = 1'b0;
   int          bitc = 16;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] d;
   int          t0;

   assign rx = loop_en ? tx : rx_drv;

   uart_v2 dut (
      .clk(clk), .reset(reset), .sel(sel), .we(we), .regsel(regsel),
      .din(din), .dout(dout), .irq(irq), .tx(tx), .rx(rx)
   );

   always #5 clk = ~clk;

   // free-running cycle count for positioning inside frames
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr_reg(input logic [2:0] idx, input logic [31:0] v);
      @(negedge clk);
      sel = 1'b1; we = 1'b1; regsel = idx; din = v;
      @(posedge clk);
      #1 sel = 1'b0; we = 1'b0;
   endtask

   task automatic rd_reg(input logic [2:0] idx, output logic [31:0] v);
      @(negedge clk);
      sel = 1'b1; we = 1'b0; regsel = idx;
      #1 v = dout;
      @(posedge clk);
      #1 sel = 1'b0;
   endtask

   task automatic wait_tx_low(input string tag);
      int n = 0;
      @(negedge clk);
      while (tx !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({tag, " start"}, {31'd0, tx}, 32'd0);
   endtask

   // starting at the first low cycle, check first and last cycle of each 16-cycle bit
   task automatic check_frame(input string tag, input logic [15:0] pat, input int n);
      for (int c = 0; c < 16 * n; c++) begin
         if (c > 0) @(negedge clk);
         if (c % 16 == 0 || c % 16 == 15)
            check($sformatf("%s bit%0d", tag, c / 16), {31'd0, tx}, {31'd0, pat[c / 16]});
      end
   endtask

   task automatic send_bit(input logic b);
      rx_drv = b;
      repeat (bitc) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] v, input int nb, input logic pen, input logic pb, input logic sb);
      @(negedge clk);
      send_bit(1'b0);
      for (int i = 0; i < nb; i++) send_bit(v[i]);
      if (pen) send_bit(pb);
      send_bit(sb);
      send_bit(1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst tx", {31'd0, tx}, 32'd1);
      check("rst irq", {31'd0, irq}, 32'd0);
      rd_reg(3'd4, d); check("rst status", d, 32'h02);
      rd_reg(3'd2, d); check("rst div", d, 32'd53);
      rd_reg(3'd3, d); check("rst cfg", d, 32'h03);
      rd_reg(3'd7, d); check("reg7 zero", d, 32'h0);
      rd_reg(3'd1, d); check("rst rxdata", d, 32'h0);

      // 8N1 transmit of A5 at one tick per cycle
      wr_reg(3'd2, 32'd0);
      wr_reg(3'd0, 32'hA5);
      wait_tx_low("8n1");
      check_frame("8n1", {5'b0, 2'b11, 8'hA5, 1'b0}, 10);

      // 7E2 transmit of 41: 7 data bits, even parity 0, two stop bits
      wr_reg(3'd3, 32'h16);
      wr_reg(3'd0, 32'h41);
      wait_tx_low("7e2");
      check_frame("7e2", {5'b0, 2'b11, 1'b0, 7'h41, 1'b0}, 11);
      repeat (16) @(negedge clk);
      check("7e2 idle tx", {31'd0, tx}, 32'd1);
      rd_reg(3'd4, d); check("7e2 not busy", d, 32'h02);
      wr_reg(3'd3, 32'h43);
      repeat (2) @(negedge clk);
      check("irq tx empty", {31'd0, irq}, 32'd1);

      // loopback at DIV=3
      wr_reg(3'd3, 32'h03);
      loop_en = 1'b1;
      wr_reg(3'd2, 32'd3);
      wr_reg(3'd0, 32'h00);
      wr_reg(3'd0, 32'hFF);
      wr_reg(3'd0, 32'h5A);
      repeat (2200) @(negedge clk);
      rd_reg(3'd1, d); check("loop b0", d, 32'h00);
      rd_reg(3'd1, d); check("loop b1", d, 32'hFF);
      rd_reg(3'd1, d); check("loop b2", d, 32'h5A);
      rd_reg(3'd4, d); check("loop status", d, 32'h02);
      rd_reg(3'd1, d); check("loop empty rd", d, 32'h00);
      loop_en = 1'b0;

      // odd parity frame with wrong parity and low stop bit
      wr_reg(3'd2, 32'd0);
      bitc = 16;
      wr_reg(3'd3, 32'h0B);
      send_frame(8'h5A, 8, 1'b1, 1'b0, 1'b0);
      rd_reg(3'd4, d); check("err flags", d, 32'h18);
      rd_reg(3'd1, d); check("err byte", d, 32'h5A);
      rd_reg(3'd4, d); check("err after pop", d, 32'h1A);
      wr_reg(3'd4, 32'h38);
      rd_reg(3'd4, d); check("err cleared", d, 32'h02);

      // overrun: 17 frames into a 16-entry queue
      wr_reg(3'd3, 32'h03);
      for (int i = 0; i < 17; i++) send_frame(8'h30 + 8'(i), 8, 1'b0, 1'b0, 1'b1);
      rd_reg(3'd4, d); check("ovr status", d, 32'h20);
      wr_reg(3'd3, 32'h23);
      repeat (2) @(negedge clk);
      check("irq rx", {31'd0, irq}, 32'd1);
      for (int i = 0; i < 16; i++) begin
         rd_reg(3'd1, d);
         check($sformatf("ovr byte%0d", i), d, 32'h30 + i);
      end
      rd_reg(3'd1, d); check("ovr empty rd", d, 32'h0);
      repeat (2) @(negedge clk);
      check("irq rx clear", {31'd0, irq}, 32'd0);
      wr_reg(3'd4, 32'h38);
      rd_reg(3'd4, d); check("ovr cleared", d, 32'h02);

      // reset in the middle of a transmit frame
      send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1);
      check("irq pre rst", {31'd0, irq}, 32'd1);
      wr_reg(3'd0, 32'h00);
      wait_tx_low("rst frame");
      t0 = cyc;
      for (int i = 0; i < 16; i++) wr_reg(3'd0, 32'h00);
      rd_reg(3'd4, d); check("tx full", d, 32'h05);
      while (cyc < t0 + 72) @(negedge clk);
      check("bit4 low", {31'd0, tx}, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1 check("rst mid tx", {31'd0, tx}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      check("rst mid irq", {31'd0, irq}, 32'd0);
      rd_reg(3'd4, d); check("rst mid status", d, 32'h02);
      rd_reg(3'd2, d); check("rst mid div", d, 32'd53);
      rd_reg(3'd3, d); check("rst mid cfg", d, 32'h03);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
